// File: rtl/rf_wr_arb.sv
// Two-source write-port arbiter for the 8-entry register file.
// Each source has a one-entry holding slot; slots drain by age, ties broken round-robin.
module rf_wr_arb #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [2:0]       a_reg,
  input  logic [width-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [2:0]       b_reg,
  input  logic [width-1:0] b_data,
  output logic             b_ready,
  output logic [2:0]       writeregsel,
  output logic [width-1:0] writedata,
  output logic             write,
  output logic [15:0]      wr_count,
  output logic             err
);

  logic             r_hvA, r_hvB;
  logic [2:0]       r_hrA, r_hrB;
  logic [width-1:0] r_hdA, r_hdB;
  logic             r_ageA, r_ageB;
  logic             r_rr;
  logic [15:0]      r_wrCount;
  logic             r_err;
  logic             r_pendA, r_pendB;

  logic w_both, w_tie, w_gntA, w_gntB;
  logic w_accA, w_accB, w_nextHvA, w_nextHvB;

  // Grant depends only on held state so the rf drive never sees a combinational path from the sources.
  always_comb begin
    w_both = r_hvA & r_hvB;
    w_tie  = w_both & (r_ageA == r_ageB);
    w_gntA = 1'b0;
    w_gntB = 1'b0;
    if (w_both) begin
      if (r_ageA != r_ageB) begin
        w_gntA = r_ageA;
        w_gntB = r_ageB;
      end else begin
        w_gntA = ~r_rr;
        w_gntB = r_rr;
      end
    end else begin
      w_gntA = r_hvA;
      w_gntB = r_hvB;
    end
  end

  assign a_ready     = ~r_hvA | w_gntA;
  assign b_ready     = ~r_hvB | w_gntB;
  assign w_accA      = a_valid & a_ready;
  assign w_accB      = b_valid & b_ready;
  assign w_nextHvA   = w_accA | (r_hvA & ~w_gntA);
  assign w_nextHvB   = w_accB | (r_hvB & ~w_gntB);

  assign write       = w_gntA | w_gntB;
  assign writeregsel = w_gntA ? r_hrA : (w_gntB ? r_hrB : 3'd0);
  assign writedata   = w_gntA ? r_hdA : (w_gntB ? r_hdB : '0);
  assign wr_count    = r_wrCount;
  assign err         = r_err;

  // A slot is older only if it survives unchanged while the other slot is freshly loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hvA     <= 1'b0;
      r_hvB     <= 1'b0;
      r_hrA     <= 3'd0;
      r_hrB     <= 3'd0;
      r_hdA     <= '0;
      r_hdB     <= '0;
      r_ageA    <= 1'b0;
      r_ageB    <= 1'b0;
      r_rr      <= 1'b0;
      r_wrCount <= 16'd0;
      r_err     <= 1'b0;
      r_pendA   <= 1'b0;
      r_pendB   <= 1'b0;
    end else begin
      if (w_accA) begin
        r_hrA <= a_reg;
        r_hdA <= a_data;
      end
      if (w_accB) begin
        r_hrB <= b_reg;
        r_hdB <= b_data;
      end
      r_hvA  <= w_nextHvA;
      r_hvB  <= w_nextHvB;
      r_ageA <= w_nextHvA & w_nextHvB & ~w_accA & w_accB;
      r_ageB <= w_nextHvA & w_nextHvB & ~w_accB & w_accA;
      if (w_tie)
        r_rr <= ~r_rr;
      r_wrCount <= r_wrCount + {15'd0, write};
      r_pendA   <= a_valid & ~a_ready;
      r_pendB   <= b_valid & ~b_ready;
      r_err     <= r_err | (r_pendA & ~a_valid) | (r_pendB & ~b_valid);
    end
  end

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed bench for rf_wr_arb: models the register file from the write port
// and compares outputs against hand-computed values.
module tb_rf_wr_arb;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic [2:0]    a_reg, b_reg;
  logic [W-1:0]  a_data, b_data;
  logic          a_ready, b_ready;
  logic [2:0]    writeregsel;
  logic [W-1:0]  writedata;
  logic          write;
  logic [15:0]   wr_count;
  logic          err;

  int testsRun    = 0;
  int testsFailed = 0;
  int commitCount = 0;
  int commitSnap;
  logic [W-1:0] rfModel [8];
  logic [W-1:0] streamData [4];

  always #5 clk = ~clk;

  rf_wr_arb #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .writeregsel(writeregsel), .writedata(writedata), .write(write),
    .wr_count(wr_count), .err(err)
  );

  // Stand-in register file: commits whatever the write port drives at each rising edge.
  always @(posedge clk) begin
    if (write) begin
      rfModel[writeregsel] = writedata;
      commitCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input string tag, input logic [2:0] expReg, input logic [W-1:0] expData);
    checkOutput({tag, " write"}, {31'd0, write}, 32'd1);
    checkOutput({tag, " reg"}, {29'd0, writeregsel}, {29'd0, expReg});
    checkOutput({tag, " data"}, {16'd0, writedata}, {16'd0, expData});
  endtask

  // Inputs change at the falling edge so they are stable well before the next rising edge.
  task automatic applyStimulus(input logic av, input logic [2:0] ar, input logic [W-1:0] ad,
                               input logic bv, input logic [2:0] br, input logic [W-1:0] bd);
    @(negedge clk);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) rfModel[i] = '0;
    streamData[0] = 16'h1111; streamData[1] = 16'h2222;
    streamData[2] = 16'h3333; streamData[3] = 16'h4444;
    rst = 1'b1;
    a_valid = 1'b0; a_reg = 3'd0; a_data = '0;
    b_valid = 1'b0; b_reg = 3'd0; b_data = '0;
    #2;
    checkOutput("reset write", {31'd0, write}, 32'd0);
    checkOutput("reset wr_count", {16'd0, wr_count}, 32'd0);
    checkOutput("reset a_ready", {31'd0, a_ready}, 32'd1);
    checkOutput("reset b_ready", {31'd0, b_ready}, 32'd1);
    checkOutput("reset err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single source streaming, one write per cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 3'(k + 1), streamData[k], 1'b0, 3'd0, '0);
      checkOutput($sformatf("stream a_ready %0d", k), {31'd0, a_ready}, 32'd1);
      if (k == 0)
        checkOutput("stream idle before", {31'd0, write}, 32'd0);
      else
        checkWrite($sformatf("stream %0d", k), 3'(k), streamData[k - 1]);
    end
    idle();
    checkWrite("stream 4", 3'd4, 16'h4444);
    idle();
    checkOutput("stream done write", {31'd0, write}, 32'd0);
    checkOutput("stream wr_count", {16'd0, wr_count}, 32'd4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("stream r%0d", k + 1), {16'd0, rfModel[k + 1]}, {16'd0, streamData[k]});

    // Tie then age-driven interleave: A, B, A, B.
    applyStimulus(1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd6, 16'hBBBB);
    applyStimulus(1'b1, 3'd5, 16'hA1A1, 1'b1, 3'd6, 16'hBBBB);
    checkWrite("tie g1", 3'd5, 16'hAAAA);
    checkOutput("tie b_ready blocked", {31'd0, b_ready}, 32'd0);
    checkOutput("tie a_ready drain", {31'd0, a_ready}, 32'd1);
    applyStimulus(1'b0, 3'd0, '0, 1'b1, 3'd6, 16'hB1B1);
    checkWrite("tie g2", 3'd6, 16'hBBBB);
    checkOutput("tie b_ready drain", {31'd0, b_ready}, 32'd1);
    idle();
    checkWrite("tie g3", 3'd5, 16'hA1A1);
    checkOutput("tie b_ready g3", {31'd0, b_ready}, 32'd0);
    idle();
    checkWrite("tie g4", 3'd6, 16'hB1B1);
    idle();
    checkOutput("tie drained", {31'd0, write}, 32'd0);

    // Round-robin now favours B on the next tie.
    applyStimulus(1'b1, 3'd1, 16'hC0C0, 1'b1, 3'd2, 16'hD0D0);
    idle();
    checkWrite("rr tie B first", 3'd2, 16'hD0D0);
    checkOutput("rr a_ready blocked", {31'd0, a_ready}, 32'd0);
    idle();
    checkWrite("rr tie A second", 3'd1, 16'hC0C0);
    idle();

    // Age ordering on the same register: B accepted first must commit first.
    applyStimulus(1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, '0);
    applyStimulus(1'b1, 3'd7, 16'h7778, 1'b1, 3'd3, 16'h0B0B);
    checkWrite("age pre", 3'd7, 16'h7777);
    applyStimulus(1'b1, 3'd3, 16'h0A0A, 1'b0, 3'd0, '0);
    checkWrite("age tie A", 3'd7, 16'h7778);
    checkOutput("age b_ready blocked", {31'd0, b_ready}, 32'd0);
    idle();
    checkWrite("age B first", 3'd3, 16'h0B0B);
    checkOutput("age a_ready blocked", {31'd0, a_ready}, 32'd0);
    idle();
    checkWrite("age A second", 3'd3, 16'h0A0A);
    idle();
    checkOutput("age r3 final", {16'd0, rfModel[3]}, 32'h0A0A);
    checkOutput("err clean so far", {31'd0, err}, 32'd0);

    // Withdrawal of an unaccepted request sets the sticky error.
    applyStimulus(1'b1, 3'd1, 16'h0001, 1'b1, 3'd2, 16'h0002);
    applyStimulus(1'b1, 3'd4, 16'h0004, 1'b0, 3'd0, '0);
    checkWrite("err B wins", 3'd2, 16'h0002);
    checkOutput("err a_ready low", {31'd0, a_ready}, 32'd0);
    idle();
    checkWrite("err A drains", 3'd1, 16'h0001);
    checkOutput("err not yet", {31'd0, err}, 32'd0);
    idle();
    checkOutput("err set", {31'd0, err}, 32'd1);
    idle();
    idle();
    checkOutput("err sticky", {31'd0, err}, 32'd1);

    // Asynchronous reset mid-cycle with a held entry.
    applyStimulus(1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, '0);
    idle();
    checkOutput("pre-reset write", {31'd0, write}, 32'd1);
    #2 rst = 1'b1;
    #1;
    commitSnap = commitCount;
    checkOutput("async reset write", {31'd0, write}, 32'd0);
    checkOutput("async reset sel", {29'd0, writeregsel}, 32'd0);
    checkOutput("async reset data", {16'd0, writedata}, 32'd0);
    checkOutput("async reset wr_count", {16'd0, wr_count}, 32'd0);
    checkOutput("async reset a_ready", {31'd0, a_ready}, 32'd1);
    checkOutput("async reset b_ready", {31'd0, b_ready}, 32'd1);
    checkOutput("async reset err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    idle();
    idle();
    checkOutput("held entry discarded", 32'(commitCount), 32'(commitSnap));
    checkOutput("r6 untouched", {16'd0, rfModel[6]}, 32'hB1B1);

    // Stream 65537 writes to register 0 so the counter wraps to 1.
    for (int i = 0; i < 65537; i++) begin
      applyStimulus(1'b1, 3'd0, 16'(i + 5), 1'b0, 3'd0, '0);
      if (i == 1) checkWrite("reg0 forward", 3'd0, 16'h0005);
    end
    idle();
    idle();
    checkOutput("wrap write idle", {31'd0, write}, 32'd0);
    checkOutput("wrap wr_count", {16'd0, wr_count}, 32'd1);
    checkOutput("wrap r0 last", {16'd0, rfModel[0]}, 32'd5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
